// File: rtl/apb_cmd_bridge.sv
// Host command bridge for the APB subsystem: queues commands and issues them one at a time.
// Latency: pop one cycle after a push into an empty FIFO, then ACCESS_CYCLES + 2 more cycles to rsp_valid.
// Backpressure: cmd_ready drops when the FIFO is full; no pop while a response is pending. Option: APB_BRIDGE_ERR_CNT_EN.
module apb_cmd_bridge #(
  parameter int WIDTH         = 7,
  parameter int DEPTH         = 4,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH:0]   cmd_addr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_write,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             transfer,
  output logic             read_write,
  output logic [WIDTH:0]   write_paddr,
  output logic [WIDTH:0]   read_paddr,
  output logic [WIDTH-1:0] write_data,
  input  logic [WIDTH-1:0] read_data_out,
  input  logic             PSLVERR
`ifdef APB_BRIDGE_ERR_CNT_EN
  ,
  input  logic             clr_err_count,
  output logic [7:0]       err_count
`endif
);

  localparam int AW = WIDTH + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CYC_LAST = CW'(ACCESS_CYCLES - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  // Command FIFO storage and bookkeeping
  logic             r_mem_write [DEPTH];
  logic [AW-1:0]    r_mem_addr  [DEPTH];
  logic [WIDTH-1:0] r_mem_wdata [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             r_cmd_ready;

  // Sequencer state and the command currently on the APB side
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cyc;
  logic             r_iss_write;
  logic [AW-1:0]    r_iss_addr;
  logic [WIDTH-1:0] r_iss_wdata;

  // Response holding register
  logic             r_rsp_valid;
  logic             r_rsp_write;
  logic [WIDTH-1:0] r_rsp_rdata;
  logic             r_rsp_err;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_hold;
  logic [PW:0]      w_count_nxt;

  assign w_push    = cmd_valid & r_cmd_ready;
  assign w_empty   = (r_count == '0);
  assign cmd_ready = r_cmd_ready;

  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  // FIFO payload storage; contents are meaningless outside the valid window so no reset
  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_mem_write[r_wr_ptr] <= cmd_write;
      r_mem_addr[r_wr_ptr]  <= cmd_addr;
      r_mem_wdata[r_wr_ptr] <= cmd_wdata;
    end
  end

  // FIFO pointers, count and registered ready (held low while in reset)
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count     <= w_count_nxt;
      r_cmd_ready <= (w_count_nxt != FULL_CNT);
    end
  end

  // Next-state, pop decision and APB-side outputs
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A response slot is free if empty or being drained this very cycle
        if (!w_empty && (!r_rsp_valid || rsp_ready)) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (r_cyc == CYC_LAST) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: w_state_nxt = S_GAP;
      S_GAP:     w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase

    // Address/data/direction are held through CAPTURE so the slave sees a stable bus
    w_hold      = (r_state == S_ISSUE) || (r_state == S_CAPTURE);
    transfer    = (r_state == S_ISSUE);
    read_write  = w_hold & r_iss_write;
    write_paddr = (w_hold && r_iss_write)  ? r_iss_addr  : '0;
    read_paddr  = (w_hold && !r_iss_write) ? r_iss_addr  : '0;
    write_data  = w_hold                   ? r_iss_wdata : '0;
  end

  // State register and access-window cycle counter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        r_cyc <= '0;
      end else if (r_state == S_ISSUE) begin
        r_cyc <= r_cyc + CYC_ONE;
      end
    end
  end

  // Issue registers: loaded from the FIFO head on pop
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_iss_write <= 1'b0;
      r_iss_addr  <= '0;
      r_iss_wdata <= '0;
    end else if (w_pop) begin
      r_iss_write <= r_mem_write[r_rd_ptr];
      r_iss_addr  <= r_mem_addr[r_rd_ptr];
      r_iss_wdata <= r_mem_wdata[r_rd_ptr];
    end
  end

  // Response register: CAPTURE loads (and wins over a same-cycle handshake), handshake clears valid
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (r_state == S_CAPTURE) begin
      r_rsp_valid <= 1'b1;
      r_rsp_write <= r_iss_write;
      r_rsp_rdata <= r_iss_write ? '0 : read_data_out;
      r_rsp_err   <= PSLVERR;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef APB_BRIDGE_ERR_CNT_EN
  logic [7:0] r_err_count;
  assign err_count = r_err_count;

  // Saturating slave-error counter; a clear request beats a same-cycle increment
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_err_count <= 8'd0;
    end else if (clr_err_count) begin
      r_err_count <= 8'd0;
    end else if ((r_state == S_CAPTURE) && PSLVERR && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_apb_cmd_bridge.sv
module tb_apb_cmd_bridge;
  localparam int WIDTH = 7;
  localparam int DEPTH = 4;
  localparam int ACC   = 3;

  logic       PCLK;
  logic       PRESETn;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [6:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic       rsp_write;
  logic [6:0] rsp_rdata;
  logic       rsp_err;
  logic       transfer;
  logic       read_write;
  logic [7:0] write_paddr;
  logic [7:0] read_paddr;
  logic [6:0] write_data;
  logic [6:0] read_data_out;
  logic       PSLVERR;
`ifdef APB_BRIDGE_ERR_CNT_EN
  logic       clr_err_count;
  logic [7:0] err_count;
`endif

  apb_cmd_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ACCESS_CYCLES(ACC)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .transfer(transfer), .read_write(read_write), .write_paddr(write_paddr),
    .read_paddr(read_paddr), .write_data(write_data),
    .read_data_out(read_data_out), .PSLVERR(PSLVERR)
`ifdef APB_BRIDGE_ERR_CNT_EN
    , .clr_err_count(clr_err_count), .err_count(err_count)
`endif
  );

  typedef struct { logic w; logic [7:0] a; logic [6:0] d; } cmd_t;
  typedef struct { logic w; logic [6:0] rd; logic err; } rsp_t;
  typedef struct { logic w; logic [7:0] a; logic [6:0] d; logic ew; logic [6:0] erd; logic eerr; } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rsp = 0;
  int   cyc   = 0;
  int   rsp_mode = 1;   // 0: never accept, 1: always accept, 2: random
  cmd_t iss_q[$];
  rsp_t exp_q[$];
  int   rise_q[$];

  // Slave side: a plain memory; PSLVERR flags any address whose low 3 bits are all ones
  logic [6:0] slv_mem [256] = '{default: 7'd0};
  logic [6:0] mdl_mem [256] = '{default: 7'd0};

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;
  always @(posedge PCLK) if (transfer && read_write) slv_mem[write_paddr] <= write_data;
  assign read_data_out = slv_mem[read_paddr];
  assign PSLVERR = ((read_write ? write_paddr[2:0] : read_paddr[2:0]) == 3'd7);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bus_act(input logic mask_wd);
    return {8'd0, read_write, write_paddr, read_paddr, mask_wd ? 7'd0 : write_data};
  endfunction

  function automatic logic [31:0] bus_exp(input cmd_t c);
    return {8'd0, c.w, c.w ? c.a : 8'd0, c.w ? 8'd0 : c.a, c.w ? c.d : 7'd0};
  endfunction

  // Reference behaviour: commands execute strictly in order against a flat memory
  task automatic model_exec(input cmd_t c, output rsp_t r);
    r.w   = c.w;
    r.err = (c.a[2:0] == 3'd7);
    if (c.w) begin
      mdl_mem[c.a] = c.d;
      r.rd = 7'd0;
    end else begin
      r.rd = mdl_mem[c.a];
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic push(input cmd_t c, input rsp_t e);
    int n;
    cmd_write = c.w; cmd_addr = c.a; cmd_wdata = c.d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) begin
      chk("push_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      iss_q.push_back(c);
      exp_q.push_back(e);
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic push_model(input logic w, input logic [7:0] a, input logic [6:0] d);
    cmd_t c;
    rsp_t e;
    c = '{w, a, d};
    model_exec(c, e);
    push(c, e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || iss_q.size() != 0) && n < budget) begin
      @(negedge PCLK);
      n++;
    end
    chk("drain_pending_rsp", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge PCLK);
  endtask

  // APB-side monitor: transfer length, bus contents while issuing/capturing, quiet bus otherwise
  initial begin : iss_mon
    cmd_t cur;
    int   run;
    logic prev;
    cur = '{1'b0, 8'd0, 7'd0};
    run = 0;
    prev = 1'b0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        run = 0;
        prev = 1'b0;
      end else begin
        if (transfer) begin
          if (!prev) begin
            rise_q.push_back(cyc);
            if (iss_q.size() == 0) chk("unexpected_transfer", 32'(iss_q.size()), 32'd1);
            else cur = iss_q.pop_front();
          end
          chk("issue_bus", bus_act(!cur.w), bus_exp(cur));
          run++;
        end else if (prev) begin
          chk("transfer_len", 32'(run), 32'(ACC));
          chk("capture_bus", bus_act(!cur.w), bus_exp(cur));
          run = 0;
        end else begin
          chk("idle_bus", bus_act(1'b0), 32'd0);
        end
        prev = transfer;
      end
    end
  end

  // Response monitor: drives rsp_ready, checks order/content and stability while stalled
  initial begin : rsp_mon
    rsp_t held;
    rsp_t e;
    logic stall;
    stall = 1'b0;
    held = '{1'b0, 7'd0, 1'b0};
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
          chk("rsp_hold_data", 32'({rsp_write, rsp_rdata, rsp_err}), 32'({held.w, held.rd, held.err}));
        end
        case (rsp_mode)
          0:       rsp_ready = 1'b0;
          1:       rsp_ready = 1'b1;
          default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_write", 32'(rsp_write), 32'(e.w));
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
            chk("rsp_err",   32'(rsp_err),   32'(e.err));
          end
          n_rsp++;
          stall = 1'b0;
        end else if (rsp_valid) begin
          stall = 1'b1;
          held = '{rsp_write, rsp_rdata, rsp_err};
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[8];
    cmd_t c;
    rsp_t e;
    rsp_t me;
    int   n0;
    int   n;

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'd0; cmd_wdata = 7'd0;
`ifdef APB_BRIDGE_ERR_CNT_EN
    clr_err_count = 1'b0;
`endif
    PRESETn = 1'b0;
    rsp_mode = 1;
    repeat (2) @(negedge PCLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_transfer",  32'(transfer),  32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_apb_bus",   bus_act(1'b0),  32'd0);
    chk("rst_rsp_data",  32'({rsp_write, rsp_rdata, rsp_err}), 32'd0);
    #2 PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("cmd_ready_after_rst", 32'(cmd_ready), 32'd1);
`ifdef APB_BRIDGE_ERR_CNT_EN
    chk("err_count_rst", 32'(err_count), 32'd0);
`endif

    // Directed vectors: {cmd, addr, wdata, expected rsp_write, rsp_rdata, rsp_err}
    tbl[0] = '{1'b1, 8'h85, 7'h2A, 1'b1, 7'h00, 1'b0};
    tbl[1] = '{1'b1, 8'h03, 7'h11, 1'b1, 7'h00, 1'b0};
    tbl[2] = '{1'b0, 8'h03, 7'h00, 1'b0, 7'h11, 1'b0};
    tbl[3] = '{1'b0, 8'h85, 7'h00, 1'b0, 7'h2A, 1'b0};
    tbl[4] = '{1'b0, 8'h07, 7'h00, 1'b0, 7'h00, 1'b1};
    tbl[5] = '{1'b1, 8'h8F, 7'h55, 1'b1, 7'h00, 1'b1};
    tbl[6] = '{1'b0, 8'h8F, 7'h00, 1'b0, 7'h55, 1'b1};
    tbl[7] = '{1'b0, 8'h86, 7'h00, 1'b0, 7'h00, 1'b0};
    for (int i = 0; i < 8; i++) begin
      c = '{tbl[i].w, tbl[i].a, tbl[i].d};
      e = '{tbl[i].ew, tbl[i].erd, tbl[i].eerr};
      model_exec(c, me);
      push(c, e);
      drain(100);
    end
`ifdef APB_BRIDGE_ERR_CNT_EN
    chk("err_count_after_table", 32'(err_count), 32'd3);
    clr_err_count = 1'b1;
    @(negedge PCLK);
    clr_err_count = 1'b0;
    chk("err_count_cleared", 32'(err_count), 32'd0);
`endif

    // Back-to-back reads with rsp_ready high: rising edges ACC+3 cycles apart
    rise_q.delete();
    push_model(1'b0, 8'h03, 7'h00);
    push_model(1'b0, 8'h85, 7'h00);
    push_model(1'b0, 8'h86, 7'h00);
    drain(200);
    chk("spacing_count", 32'(rise_q.size()), 32'd3);
    if (rise_q.size() == 3) begin
      chk("spacing_1", 32'(rise_q[1] - rise_q[0]), 32'(ACC + 3));
      chk("spacing_2", 32'(rise_q[2] - rise_q[1]), 32'(ACC + 3));
    end

    // Backpressure: five commands with responses refused
    rsp_mode = 0;
    @(negedge PCLK);
    rise_q.delete();
    n0 = n_rsp;
    push_model(1'b1, 8'h81, 7'h0A);
    push_model(1'b0, 8'h81, 7'h00);
    push_model(1'b1, 8'h02, 7'h33);
    push_model(1'b0, 8'h02, 7'h00);
    push_model(1'b0, 8'h85, 7'h00);
    chk("bp_full_cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (20) @(negedge PCLK);
    chk("bp_single_transfer", 32'(rise_q.size()), 32'd1);
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_still_full", 32'(cmd_ready), 32'd0);
    rsp_mode = 1;
    drain(400);
    chk("bp_rsp_count", 32'(n_rsp - n0), 32'd5);

    // Reset in the middle of ISSUE with two commands still queued
    push_model(1'b0, 8'h85, 7'h00);
    push_model(1'b0, 8'h03, 7'h00);
    push_model(1'b0, 8'h86, 7'h00);
    n = 0;
    while (!transfer && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    chk("wait_transfer", 32'(transfer), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("midrst_transfer",  32'(transfer),  32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    exp_q.delete();
    iss_q.delete();
    rise_q.delete();
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b1;
    repeat (20) @(negedge PCLK);
    chk("no_stale_transfer", 32'(rise_q.size()), 32'd0);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    push_model(1'b0, 8'h85, 7'h00);
    drain(100);
    chk("post_rst_one_transfer", 32'(rise_q.size()), 32'd1);

    // Randomized traffic with random response acceptance
    rsp_mode = 2;
    for (int i = 0; i < 60; i++) begin
      push_model(1'($urandom_range(0, 1)),
                 {1'($urandom_range(0, 1)), 4'b0000, 3'($urandom_range(0, 7))},
                 7'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge PCLK);
    end
    drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/apb_cmd_bridge.md
Name: apb_cmd_bridge

Overview:
- Host-side bridge directly upstream of the APB subsystem (master + slave1/slave2 with scan muxing).
- Buffers host read/write commands in a small FIFO and drives the subsystem's transfer / read_write / write_paddr / read_paddr / write_data inputs one command at a time.
- Captures read_data_out and PSLVERR after a fixed access window and returns one response per command over a valid/ready channel.

Parameters:
- WIDTH, 7, data width. Address width is WIDTH+1; address bit WIDTH selects slave1 (1) or slave2 (0).
- DEPTH, 4, command FIFO depth (power of 2, at least 2).
- ACCESS_CYCLES, 3, number of cycles transfer is held high per command (covers APB SETUP + ACCESS + PREADY).

Ports:
- PCLK  in  1  clock; single clock domain.
- PRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  WIDTH+1  target address.
- cmd_wdata  in  WIDTH  write data (ignored for reads).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host accepts response.
- rsp_write  out  1  echo of the command type.
- rsp_rdata  out  WIDTH  captured read data (0 for writes).
- rsp_err  out  1  captured PSLVERR.
- transfer  out  1  to APB subsystem.
- read_write  out  1  to APB subsystem; 1 = write, 0 = read.
- write_paddr  out  WIDTH+1  to APB subsystem.
- read_paddr  out  WIDTH+1  to APB subsystem.
- write_data  out  WIDTH  to APB subsystem.
- read_data_out  in  WIDTH  from APB subsystem.
- PSLVERR  in  1  from APB subsystem.

Behaviour:
- Reset (async, PRESETn=0):
  - FIFO emptied; FSM to IDLE.
  - transfer=0, read_write=0, all address/data outputs 0.
  - rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0; cmd_ready=0 while reset is asserted.
  - Reset mid-operation aborts the command in flight with no response, and discards queued commands.
- Command FIFO:
  - Push when cmd_valid & cmd_ready. cmd_ready = !full (registered).
  - Simultaneous push and pop when full is not allowed, since cmd_ready=0. Simultaneous push and pop at any other occupancy keeps the count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, CAPTURE, GAP.
- IDLE:
  - If FIFO non-empty and response slot free (rsp_valid=0, or rsp_valid & rsp_ready this cycle): pop the head into issue registers and go to ISSUE.
  - Issue registers drive read_write, write_data, and either write_paddr (write; read_paddr=0) or read_paddr (read; write_paddr=0).
- ISSUE:
  - transfer=1; cycle counter runs 0..ACCESS_CYCLES-1.
  - At count ACCESS_CYCLES-1, go to CAPTURE.
  - Address, data and direction stay stable throughout.
- CAPTURE (1 cycle):
  - transfer=0; address, data and direction still held.
  - At the clock edge load the response: rsp_rdata = read ? read_data_out : 0; rsp_err = PSLVERR; rsp_write = command type.
  - Set rsp_valid=1, then go to GAP.
- GAP (1 cycle):
  - transfer=0; all APB-side outputs return to 0. Lets the master return to IDLE.
  - Go to IDLE.
- Timing:
  - Minimum command-to-command spacing is ACCESS_CYCLES+3 cycles.
  - transfer first goes high the cycle after the pop edge.
  - Minimum latency from push into an empty FIFO to rsp_valid is ACCESS_CYCLES+3 cycles.
- Response channel:
  - Response is held stable while rsp_valid & !rsp_ready.
  - Cleared on handshake unless a new response loads in the same cycle; CAPTURE has priority (it sets rsp_valid=1).
- Backpressure: FSM never pops while a response is pending and not being accepted. Commands keep queuing until the FIFO is full.
- Ordering: responses are strictly in command order; exactly one response per command.

Optional Feature:
- Macro: APB_BRIDGE_ERR_CNT_EN.
- Defined:
  - Extra output err_count [7:0], reset 0.
  - Increments in CAPTURE when PSLVERR=1; saturates at 255.
  - Input clr_err_count (1 bit) clears it synchronously; clear wins over increment.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Reset, then write cmd (addr 8'h85, wdata 7'h2A) -> transfer high for exactly 3 cycles with read_write=1, write_paddr=8'h85, read_paddr=0, write_data=7'h2A; then rsp_valid=1, rsp_write=1, rsp_rdata=0, rsp_err=0.
- Write 7'h11 to 8'h03 (slave2), then read 8'h03 -> second response rsp_write=0, rsp_rdata=7'h11, read_paddr=8'h03 during its ISSUE.
- Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready drops after 4 are queued (1 popped plus FIFO full); no second transfer until the first response is accepted; all 5 responses arrive in order once rsp_ready=1.
- Force PSLVERR=1 during a read's CAPTURE cycle -> rsp_err=1; with APB_BRIDGE_ERR_CNT_EN, err_count goes 0→1; after 256 errors it stays at 255.
- Assert PRESETn=0 mid-ISSUE with 2 commands queued -> transfer=0 immediately, rsp_valid=0, FIFO empty; after release, no stale transfer is issued.
- rsp_ready held high, 3 reads queued -> transfer pulses spaced exactly ACCESS_CYCLES+3 = 6 cycles apart (rising edge to rising edge).
